// File: rtl/button_event_decoder_pkg.sv
// ---------------------------------------------------------------------------
// button_event_pkg
//   Shared types and constants for the button event decoder.
//   - state_t : decoder FSM states
//   - event_t : sticky last-event code presented to the menu logic
//   - SIM_*   : short tick counts used when SIMULACION = 1
//   - cnt_width / max3 : helpers that size the single shared counter
// ---------------------------------------------------------------------------
package button_event_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD  = 3'd1,
        WAIT2 = 3'd2,
        HELD2 = 3'd3,
        LONG  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_SHORT  = 2'd1,
        EV_LONG   = 2'd2,
        EV_DOUBLE = 2'd3
    } event_t;

    localparam int unsigned SIM_LONG_TICKS   = 8;
    localparam int unsigned SIM_DOUBLE_TICKS = 4;
    localparam int unsigned SIM_REPEAT_TICKS = 3;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // The counter only ever reaches (ticks - 1), so $clog2(ticks) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned ticks);
        return (ticks <= 1) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//   Turns debounced press/release strobes from one button into user events:
//   short press, long press, double click and auto-repeat while long-held.
//   One FSM and one shared tick counter; all outputs registered.
//
// Parameters
//   CLK_HZ     system clock frequency in Hz
//   SIMULACION 1 selects short tick counts (8 / 4 / 3)
//   LONG_MS    hold time that qualifies a long press
//   DOUBLE_MS  max release-to-second-press gap for a double click
//   REPEAT_MS  auto-repeat period after a long press
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high
//   press_pulse    one-cycle strobe on debounced press
//   release_pulse  one-cycle strobe on debounced release
//   short_press    one-cycle pulse: single short press confirmed
//   long_press     one-cycle pulse: hold reached long threshold
//   double_click   one-cycle pulse: second press inside double window
//   repeat_pulse   one-cycle pulse every repeat period while long-held
//   last_event     sticky code of most recent event (0/1/2/3)
//   dbg_state      current FSM state, for observation only
//
// Handshake: press_pulse / release_pulse are single-cycle strobes with no
// back-pressure; every strobe is consumed on the edge it is sampled. A cycle
// carrying both strobes is illegal upstream and is treated as carrying none.
// ---------------------------------------------------------------------------
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 16_000_000,
    parameter bit          SIMULACION = 1'b0,
    parameter int unsigned LONG_MS    = 800,
    parameter int unsigned DOUBLE_MS  = 300,
    parameter int unsigned REPEAT_MS  = 150
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press_pulse,
    input  logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       repeat_pulse,
    output logic [1:0] last_event,
    output state_t     dbg_state
);

    localparam int unsigned TICKS_PER_MS = CLK_HZ / 1000;

    localparam int unsigned LONG_TICKS   = SIMULACION ? SIM_LONG_TICKS
                                                      : TICKS_PER_MS * LONG_MS;
    localparam int unsigned DOUBLE_TICKS = SIMULACION ? SIM_DOUBLE_TICKS
                                                      : TICKS_PER_MS * DOUBLE_MS;
    localparam int unsigned REPEAT_TICKS = SIMULACION ? SIM_REPEAT_TICKS
                                                      : TICKS_PER_MS * REPEAT_MS;

    localparam int unsigned CNT_W = cnt_width(max3(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS));

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_short;
    logic             r_long;
    logic             r_double;
    logic             r_repeat;
    event_t           r_last;

    // Both strobes in one cycle is an upstream fault: mask it to "no event".
    logic w_press;
    logic w_release;
    assign w_press   = press_pulse   & ~release_pulse;
    assign w_release = release_pulse & ~press_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_repeat <= 1'b0;
            r_last   <= EV_NONE;
        end else begin
            // Event pulses live for exactly one cycle.
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_repeat <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_press) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end
                end

                // Release is checked first so it wins over the long timeout.
                HELD: begin
                    if (w_release) begin
                        r_state <= WAIT2;
                        r_cnt   <= '0;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state <= LONG;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                        r_last  <= EV_LONG;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                // Press is checked first so it wins over the double timeout.
                WAIT2: begin
                    if (w_press) begin
                        r_state  <= HELD2;
                        r_cnt    <= '0;
                        r_double <= 1'b1;
                        r_last   <= EV_DOUBLE;
                    end else if (r_cnt == DOUBLE_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_short <= 1'b1;
                        r_last  <= EV_SHORT;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                // Hold after a double click is untimed: never becomes a long press.
                HELD2: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end

                LONG: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == REPEAT_LAST) begin
                        r_cnt    <= '0;
                        r_repeat <= 1'b1;
                        r_last   <= EV_LONG;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_click = r_double;
    assign repeat_pulse = r_repeat;
    assign last_event   = r_last;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;
  import button_event_pkg::*;

  localparam int W = 35;  // {cycle[31:0], event id[2:0]}
  localparam logic [2:0] ID_SHORT  = 3'd1;
  localparam logic [2:0] ID_LONG   = 3'd2;
  localparam logic [2:0] ID_DOUBLE = 3'd3;
  localparam logic [2:0] ID_REPEAT = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic press_pulse;
  logic release_pulse;
  logic short_press, long_press, double_click, repeat_pulse;
  logic [1:0] last_event;
  state_t dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  button_event_decoder #(
    .CLK_HZ(16_000_000),
    .SIMULACION(1'b1),
    .LONG_MS(800),
    .DOUBLE_MS(300),
    .REPEAT_MS(150)
  ) dut (
    .clk(clk),
    .reset(reset),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .short_press(short_press),
    .long_press(long_press),
    .double_click(double_click),
    .repeat_pulse(repeat_pulse),
    .last_event(last_event),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] mk(input int c, input logic [2:0] id);
    return {32'(c), id};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    int n;
    logic [2:0] id;
    logic [1:0] code;
    logic [W-1:0] obs;
    logic [W-1:0] e;
    if (reset === 1'b0) begin
      n = int'(short_press) + int'(long_press) + int'(double_click) + int'(repeat_pulse);
      if (n > 1) begin
        total++;
        bad++;
        $display("FAIL onehot cyc=%0d got %0d pulses, need at most 1", cyc, n);
      end
      if (n != 0) begin
        id = short_press ? ID_SHORT : long_press ? ID_LONG : double_click ? ID_DOUBLE : ID_REPEAT;
        code = (id == ID_SHORT) ? 2'd1 : (id == ID_DOUBLE) ? 2'd3 : 2'd2;
        obs = mk(cyc, id);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cyc=%0d id=%0d, none expected", cyc, id);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL event got cyc=%0d id=%0d need cyc=%0d id=%0d",
                     cyc, id, e[W-1:3], e[2:0]);
          end
        end
        total++;
        if (last_event !== code) begin
          bad++;
          $display("FAIL last_event_at_pulse cyc=%0d got %0d need %0d", cyc, last_event, code);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic p, input logic r);
    @(negedge clk);
    press_pulse = p;
    release_pulse = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic check_drained(input string name, input logic [1:0] want_last);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing got %0d pending events need 0", name, exp_q.size());
      exp_q.delete();
    end
    total++;
    if (last_event !== want_last) begin
      bad++;
      $display("FAIL %s_last got %0d need %0d", name, last_event, want_last);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    press_pulse = 1'b0;
    release_pulse = 1'b0;
    idle(3);
    total++;
    if ({short_press, long_press, double_click, repeat_pulse, last_event} !== 6'd0
        || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state got outs=%b state=%0d need 0/IDLE",
               {short_press, long_press, double_click, repeat_pulse, last_event}, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_short();
    int t, r, hold;
    for (int k = 0; k < 2; k++) begin
      hold = (k == 0) ? 3 : int'($urandom_range(1, 6));
      tick(1'b1, 1'b0);
      t = cyc;
      idle(hold - 1);
      tick(1'b0, 1'b1);
      r = cyc;
      exp_q.push_back(mk(r + 5, ID_SHORT));
      idle(10);
      check_drained("short", 2'd1);
    end
  endtask

  task automatic test_long_repeat();
    int t;
    tick(1'b1, 1'b0);
    t = cyc;
    exp_q.push_back(mk(t + 9, ID_LONG));
    exp_q.push_back(mk(t + 12, ID_REPEAT));
    exp_q.push_back(mk(t + 15, ID_REPEAT));
    exp_q.push_back(mk(t + 18, ID_REPEAT));
    idle(19);
    tick(1'b0, 1'b1);  // cycle t+20: release beats the next repeat
    idle(10);
    check_drained("long", 2'd2);
  endtask

  task automatic test_double();
    int p2, gap;
    for (int k = 0; k < 2; k++) begin
      gap = (k == 0) ? 2 : int'($urandom_range(1, 4));
      tick(1'b1, 1'b0);
      idle(1);
      tick(1'b0, 1'b1);
      idle(gap - 1);
      tick(1'b1, 1'b0);
      p2 = cyc;
      exp_q.push_back(mk(p2 + 1, ID_DOUBLE));
      idle(19);
      tick(1'b0, 1'b1);
      idle(10);
      check_drained("double", 2'd3);
    end
  endtask

  task automatic test_boundary_long();
    int t;
    tick(1'b1, 1'b0);
    t = cyc;
    idle(7);
    tick(1'b0, 1'b1);  // cycle t+8: counter sits at LONG_TICKS-1
    exp_q.push_back(mk(t + 13, ID_SHORT));
    idle(10);
    check_drained("bound_long", 2'd1);
  endtask

  task automatic test_boundary_wait2();
    int r;
    tick(1'b1, 1'b0);
    idle(1);
    tick(1'b0, 1'b1);
    r = cyc;
    idle(3);
    tick(1'b1, 1'b0);  // cycle r+4: WAIT2 timeout cycle
    exp_q.push_back(mk(r + 5, ID_DOUBLE));
    idle(3);
    tick(1'b0, 1'b1);
    idle(10);
    check_drained("bound_wait2", 2'd3);
  endtask

  task automatic test_reset_long();
    int t;
    tick(1'b1, 1'b0);
    t = cyc;
    exp_q.push_back(mk(t + 9, ID_LONG));
    exp_q.push_back(mk(t + 12, ID_REPEAT));
    idle(12);  // repeat_pulse is high in this cycle
    #2 reset = 1'b1;
    #1;
    total++;
    if ({short_press, long_press, double_click, repeat_pulse, last_event} !== 6'd0
        || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_in_long got outs=%b state=%0d need 0/IDLE",
               {short_press, long_press, double_click, repeat_pulse, last_event}, dbg_state);
    end
    idle(2);
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    tick(1'b0, 1'b1);
    idle(10);
    check_drained("reset_long", 2'd0);
  endtask

  task automatic test_reset_wait2();
    int r;
    tick(1'b1, 1'b0);
    idle(1);
    tick(1'b0, 1'b1);
    r = cyc;
    exp_q.push_back(mk(r + 5, ID_SHORT));
    idle(6);
    check_drained("pre_wait2", 2'd1);
    tick(1'b1, 1'b0);
    idle(1);
    tick(1'b0, 1'b1);
    idle(2);  // in WAIT2
    #2 reset = 1'b1;
    #1;
    total++;
    if (last_event !== 2'd0 || short_press !== 1'b0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_in_wait2 got last=%0d short=%b state=%0d need 0/0/IDLE",
               last_event, short_press, dbg_state);
    end
    idle(2);
    @(negedge clk);
    reset = 1'b0;
    idle(10);
    check_drained("reset_wait2", 2'd0);
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 1'b1);
    idle(1);
    total++;
    if (dbg_state !== IDLE) begin
      bad++;
      $display("FAIL simul_state got %0d need %0d", dbg_state, IDLE);
    end
    idle(10);
    check_drained("simul", 2'd0);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_short();
    test_long_repeat();
    test_double();
    test_boundary_long();
    test_boundary_wait2();
    test_reset_long();
    test_reset_wait2();
    test_simultaneous();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies debounced button activity into user-level events: short press, long press, double click and auto-repeat while held. Sits directly downstream of the per-button debouncer and consumes its `press_pulse` / `release_pulse` one-cycle strobes. Emits one-cycle event pulses plus a sticky last-event code to the menu/control logic. One instance per physical button.

## Interface
- `CLK_HZ`, 16_000_000: system clock frequency in Hz.
- `SIMULACION`, 0: 1 selects the short simulation tick counts below.
- `LONG_MS`, 800: hold time that qualifies a long press (hardware).
- `DOUBLE_MS`, 300: maximum release-to-second-press gap for a double click (hardware).
- `REPEAT_MS`, 150: auto-repeat period after a long press (hardware).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clock clk.
- `press_pulse`  in  1  one-cycle strobe on debounced press.
- `release_pulse`  in  1  one-cycle strobe on debounced release.
- `short_press`  out  1  one-cycle pulse: single short press confirmed.
- `long_press`  out  1  one-cycle pulse: hold reached LONG threshold.
- `double_click`  out  1  one-cycle pulse: second press within DOUBLE window.
- `repeat_pulse`  out  1  one-cycle pulse every REPEAT period while long-held.
- `last_event`  out  2  sticky code of most recent event: 0 none, 1 short, 2 long/repeat, 3 double.

## Operation
- Tick counts: `X_TICKS = (CLK_HZ/1000)*X_MS` in hardware; with SIMULACION=1: LONG_TICKS=8, DOUBLE_TICKS=4, REPEAT_TICKS=3.
- Single shared counter; width = $clog2 of the largest tick count (minimum 1).
- Same-cycle `press_pulse` and `release_pulse` are illegal upstream; the block treats that cycle as no event.
- States: IDLE, HELD, WAIT2, HELD2, LONG.
- IDLE: `press_pulse` -> HELD, cnt=0.
- HELD: `release_pulse` -> WAIT2, cnt=0. Otherwise, cnt==LONG_TICKS-1 -> LONG, fire `long_press`, cnt=0. Otherwise cnt++.
- Release wins over timeout in the same cycle.
- WAIT2: `press_pulse` -> HELD2, fire `double_click`. Otherwise, cnt==DOUBLE_TICKS-1 -> IDLE, fire `short_press`. Otherwise cnt++.
- Press wins over timeout in the same cycle.
- HELD2: no timing. `release_pulse` -> IDLE. A long hold after a double click never produces `long_press`.
- LONG: `release_pulse` -> IDLE, no pulse. Otherwise, cnt==REPEAT_TICKS-1 -> fire `repeat_pulse`, cnt=0. Otherwise cnt++.
- `last_event` updates on the same edge its event pulse is registered. It holds until the next event; only reset clears it.
- At most one event pulse is high in any cycle.

## Timing
- All outputs registered. Reset value of every output: 0; state IDLE; cnt 0.
- Event pulses are high exactly one cycle.
- Each pulse is asserted on the clock edge where the triggering condition is evaluated, so it is visible the cycle after the condition.
- `double_click`: high the cycle after the second `press_pulse`.
- `long_press`: press strobe at cycle t -> pulse high at t+1+LONG_TICKS.
- `short_press`: release strobe at cycle t -> pulse high at t+1+DOUBLE_TICKS if no press arrives.
- `repeat_pulse`: first pulse REPEAT_TICKS cycles after `long_press`, then every REPEAT_TICKS cycles.
- Reset mid-operation: immediate return to IDLE, all pulses low, `last_event`=0. No pending event is emitted after reset release.

## Structure
- Package `button_event_pkg`:
  - `state_t` enum (IDLE, HELD, WAIT2, HELD2, LONG);
  - `event_t` 2-bit enum (EV_NONE, EV_SHORT, EV_LONG, EV_DOUBLE);
  - sim tick constants.
- No sub-module. One FSM plus one counter in a single module.
- Top level pairs each debouncer instance with one decoder.

## Test plan
All scenarios run with SIMULACION=1.
- Short press: press at t, release at t+3, no further press -> `short_press` high at release+5 only; `last_event`=1.
- Long press with repeat: press, hold 20 cycles -> `long_press` at press+9; `repeat_pulse` at +12, +15, +18; release -> no further pulses; `last_event`=2.
- Double click: press, release after 2, press again 2 cycles later -> `double_click` the cycle after the second press, no `short_press`; holding 20 cycles gives no `long_press`.
- Boundaries:
  - release on the same cycle cnt reaches LONG_TICKS-1 -> short path, no `long_press`;
  - second press on the WAIT2 timeout cycle -> `double_click`, no `short_press`.
- Reset during LONG and during WAIT2 -> outputs 0 immediately; no `short_press` or `repeat_pulse` after release of reset.
- Simultaneous `press_pulse` and `release_pulse` in IDLE -> state stays IDLE, no pulses.
